hdmi_video_timing: RTL
======================

Name: hdmi_video_timing

Overview:
- Raster timing generator in the `clk_pix` domain. It consumes the pixel clock and reset produced by the HDMI clock/reset block.
- Produces pixel coordinates and a fetch request for the upstream frame source.
- Produces HSYNC/VSYNC/DE toward the TMDS encoder, delayed by a configurable pipeline that matches the upstream fetch latency.
- Default timing is CEA-861 1280x720p60 (74.25 MHz). 1920x1080p30 uses the same clock and is selected by parameters.

Parameters:
- H_ACTIVE, 1280, active pixels per line (1080p30: 1920)
- H_FP, 110, horizontal front porch in pixels (88)
- H_SYNC, 40, HSYNC width in pixels (44)
- H_BP, 220, horizontal back porch in pixels (148)
- V_ACTIVE, 720, active lines (1080)
- V_FP, 5, vertical front porch in lines (4)
- V_SYNC, 5, VSYNC width in lines (5)
- V_BP, 20, vertical back porch in lines (36)
- SYNC_POL, 1'b1, active level of HSYNC/VSYNC
- PIX_LAT, 2, cycles from req/x/y to hsync/vsync/de; range 0..7

Ports:
- clk_pix  in  1  pixel clock
- srst_n  in  1  reset; asynchronous, active-low
- run  in  1  1 = raster advances; 0 = counters hold
- req  out  1  pixel fetch request; high while the counter position is in the active area and run=1
- x  out  12  horizontal counter, 0..H_TOTAL-1
- y  out  11  vertical counter, 0..V_TOTAL-1
- frame_start  out  1  one-cycle pulse at x=0, y=0
- line_start  out  1  one-cycle pulse at x=0
- hsync  out  1  delayed HSYNC
- vsync  out  1  delayed VSYNC
- de  out  1  delayed data enable

Behaviour:
Counters and timing arithmetic:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Both are 1650/750 at defaults, 2200/1125 for 1080p30.
- x increments when run=1. At x=H_TOTAL-1 it wraps to 0 and y increments; y wraps to 0 after V_TOTAL-1.
- Active area: x<H_ACTIVE and y<V_ACTIVE. Active area starts at counter 0, so front porch follows active.
- HSYNC region: H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC. VSYNC region is the same form on y.
- VSYNC changes together with HSYNC region boundaries only via y, i.e. at line start. No half-line offset; progressive only.
- All counter compares are unsigned at full port width. H_TOTAL must be ≤4096 and V_TOTAL ≤2048; an elaboration-time check fails otherwise.

Registered outputs and latency:
- req, x, y, frame_start and line_start are registered and mutually aligned. They all describe the current counter position.
- frame_start = line_start & (y==0).
- hsync/vsync/de equal the decoded values for that same position, delayed by exactly PIX_LAT clk_pix cycles through a shift pipeline.
- PIX_LAT=0 means hsync/vsync/de are cycle-aligned with x/y.

run:
- run=0 freezes x/y. req, line_start and frame_start go 0.
- The delay pipeline keeps shifting, so already-issued positions drain. While frozen, the pipeline is fed de=0 and sync at the inactive level.
- When run returns to 1, the raster resumes from the frozen position.

Reset:
- Asynchronous assertion, any cycle, including mid-frame: x=0, y=0, req=0, line_start=0, frame_start=0, de=0, hsync=vsync=~SYNC_POL.
- All pipeline stages are cleared to these same values.
- On the first clk_pix edge with srst_n=1 and run=1: x=0, y=0, req=1, line_start=1, frame_start=1.
- de then rises PIX_LAT cycles later.

Boundary conditions:
- Wrap at x=H_TOTAL-1, y=V_TOTAL-1 returns to (0,0) with frame_start on the next cycle. There is no dead cycle between frames.

Optional Feature:
- Macro: VTG_TEST_PATTERN_EN.
- Defined: adds output rgb (out, 24 bits), an 8-bar colour pattern. Bar index = x*8/H_ACTIVE, computed as a compare chain, not a divider. Bars in order: white, yellow, cyan, green, magenta, red, blue, black.
- rgb is computed at counter time and carried through the same PIX_LAT pipeline, so it is aligned with de.
- rgb is forced to 0 when the delayed de=0, and resets to 0.
- Not defined: no rgb port and no pattern logic.

Decomposition:
- Shared package hdmi_pkg holds:
  - typedef vtg_t: struct of hsync, vsync, de and, under the macro, rgb
  - 720p60 and 1080p30 timing constants as localparam sets
  - the constant PIX_LAT_MAX = 7
- Sub-module vtg_delay_line: PIX_LAT-deep shift register of vtg_t with asynchronous reset to the inactive value. It is a wire-through when PIX_LAT=0.

Test Plan:
1. Reset release, defaults, run=1: frame_start at cycle 1. de first high at cycle 1+2=3. de high for 1280 consecutive cycles per line and 720 lines per frame. Total 1650*750=1,237,500 cycles per frame.
2. Sync placement: hsync rises at x=1390 and is 40 cycles wide. vsync active on lines 725..729. Check both with SYNC_POL=1 and SYNC_POL=0 (inverted levels).
3. 1080p30 parameter set: frame period 2,475,000 cycles. hsync width 44; vsync on lines 1084..1088.
4. PIX_LAT sweep 0, 3, 7: de rising edge lags req rising edge by exactly PIX_LAT cycles.
5. Pulse run=0 for 10 cycles at x=500, y=100: x/y hold at 500/100. de drains after PIX_LAT cycles and stays low. Raster resumes at x=501.
6. Assert srst_n low mid-line at x=700, y=300: all outputs take reset values immediately, before the next clock edge. After release, raster restarts at (0,0). With VTG_TEST_PATTERN_EN, rgb=FFFFFF at x=0 and 000000 at x=1279, both aligned with de.

Source files
------------

// File: rtl/hdmi_pkg.sv
// Shared types and constants for the HDMI raster timing generator.
// Optional feature macro: VTG_TEST_PATTERN_EN adds a 24-bit colour-bar
// field to vtg_t and the bar colour lookup.
package hdmi_pkg;

  // Deepest supported output delay pipeline.
  localparam int PIX_LAT_MAX = 7;

  // CEA-861 1280x720p60 at 74.25 MHz.
  localparam int H_ACTIVE_720P = 1280;
  localparam int H_FP_720P     = 110;
  localparam int H_SYNC_720P   = 40;
  localparam int H_BP_720P     = 220;
  localparam int V_ACTIVE_720P = 720;
  localparam int V_FP_720P     = 5;
  localparam int V_SYNC_720P   = 5;
  localparam int V_BP_720P     = 20;

  // CEA-861 1920x1080p30 at the same 74.25 MHz pixel clock.
  localparam int H_ACTIVE_1080P = 1920;
  localparam int H_FP_1080P     = 88;
  localparam int H_SYNC_1080P   = 44;
  localparam int H_BP_1080P     = 148;
  localparam int V_ACTIVE_1080P = 1080;
  localparam int V_FP_1080P     = 4;
  localparam int V_SYNC_1080P   = 5;
  localparam int V_BP_1080P     = 36;

  // Per-pixel video control word carried through the output delay line.
  typedef struct packed {
    logic        hsync;
    logic        vsync;
    logic        de;
`ifdef VTG_TEST_PATTERN_EN
    logic [23:0] rgb;
`endif
  } vtg_t;

  // Blanking word: no data, both syncs at their inactive level.
  function automatic vtg_t vtg_idle(input logic sync_pol);
    vtg_t v;
    v       = '0;
    v.hsync = ~sync_pol;
    v.vsync = ~sync_pol;
    return v;
  endfunction

`ifdef VTG_TEST_PATTERN_EN
  // Eight-bar pattern, left to right.
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;  // white
      3'd1:    c = 24'hFFFF00;  // yellow
      3'd2:    c = 24'h00FFFF;  // cyan
      3'd3:    c = 24'h00FF00;  // green
      3'd4:    c = 24'hFF00FF;  // magenta
      3'd5:    c = 24'hFF0000;  // red
      3'd6:    c = 24'h0000FF;  // blue
      default: c = 24'h000000;  // black
    endcase
    return c;
  endfunction
`endif

endpackage

// File: rtl/hdmi_video_timing_delay_line.sv
// PIX_LAT-deep shift register of vtg_t that aligns HSYNC/VSYNC/DE (and the
// test-pattern colour when VTG_TEST_PATTERN_EN is defined) with the
// upstream fetch latency. PIX_LAT=0 is a plain wire-through.
module vtg_delay_line
  import hdmi_pkg::*;
#(
  parameter int   PIX_LAT  = 2,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic clk_pix,
  input  logic srst_n,
  input  vtg_t d_i,
  output vtg_t q_o
);

  if (PIX_LAT == 0) begin : g_wire
    assign q_o = d_i;
  end else begin : g_pipe
    vtg_t stage_q [PIX_LAT];

    // Shift every cycle regardless of run so already-issued pixels drain.
    always_ff @(posedge clk_pix or negedge srst_n) begin
      if (!srst_n) begin
        // NOTE: every stage is reset, not just the last: the stages carry
        // sync levels straight to the encoder, so an unreset stage would put
        // a spurious sync pulse on the link after reset.
        for (int i = 0; i < PIX_LAT; i++) stage_q[i] <= vtg_idle(SYNC_POL);
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < PIX_LAT; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[PIX_LAT-1];
  end

endmodule

// File: rtl/hdmi_video_timing.sv
// Raster timing generator in the clk_pix domain: pixel coordinates and a
// fetch request for the frame source, plus HSYNC/VSYNC/DE delayed by
// PIX_LAT cycles to line up with the fetched pixel data.
// Optional feature macro: VTG_TEST_PATTERN_EN adds a 24-bit colour-bar
// output rgb aligned with de.
module hdmi_video_timing
  import hdmi_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_720P,
  parameter int   H_FP     = H_FP_720P,
  parameter int   H_SYNC   = H_SYNC_720P,
  parameter int   H_BP     = H_BP_720P,
  parameter int   V_ACTIVE = V_ACTIVE_720P,
  parameter int   V_FP     = V_FP_720P,
  parameter int   V_SYNC   = V_SYNC_720P,
  parameter int   V_BP     = V_BP_720P,
  parameter logic SYNC_POL = 1'b1,
  parameter int   PIX_LAT  = 2
) (
  input  logic        clk_pix,
  input  logic        srst_n,
  input  logic        run,
  output logic        req,
  output logic [11:0] x,
  output logic [10:0] y,
  output logic        frame_start,
  output logic        line_start,
  output logic        hsync,
  output logic        vsync,
  output logic        de
`ifdef VTG_TEST_PATTERN_EN
 ,output logic [23:0] rgb
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Region boundaries at full counter width; all compares are unsigned.
  localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
  localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);

  if (H_TOTAL > 4096 || V_TOTAL > 2048) begin : g_bad_total
    $error("hdmi_video_timing: H_TOTAL/V_TOTAL exceed the 12/11-bit counters");
  end
  if (PIX_LAT < 0 || PIX_LAT > PIX_LAT_MAX) begin : g_bad_lat
    $error("hdmi_video_timing: PIX_LAT outside 0..PIX_LAT_MAX");
  end

  // nx/ny point at the position to issue on the next run cycle; x/y hold
  // the position currently issued, so a freeze keeps both stable.
  logic [11:0] nx_q, nx_d, x_q;
  logic [10:0] ny_q, ny_d, y_q;
  logic        req_q, line_start_q, frame_start_q;
  logic        valid_q;  // x_q/y_q describe a position issued this cycle
  vtg_t        pix_d, pix_dly;

  // Next raster position with horizontal and vertical wrap.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    nx_d = nx_q + 12'd1;
    ny_d = ny_q;
    if (nx_q == H_LAST) begin
      nx_d = '0;
      ny_d = (ny_q == V_LAST) ? '0 : ny_q + 11'd1;
    end
  end

  // Issue the pointed-to position when run=1; freeze and go quiet otherwise.
  always_ff @(posedge clk_pix or negedge srst_n) begin
    if (!srst_n) begin
      nx_q          <= '0;
      ny_q          <= '0;
      x_q           <= '0;
      y_q           <= '0;
      req_q         <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      valid_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here, so every register samples the
      // pre-edge value of nx_q/ny_q regardless of statement order.
      valid_q <= run;
      if (run) begin
        x_q           <= nx_q;
        y_q           <= ny_q;
        req_q         <= (nx_q < H_ACT_END) && (ny_q < V_ACT_END);
        line_start_q  <= (nx_q == '0);
        frame_start_q <= (nx_q == '0) && (ny_q == '0);
        nx_q          <= nx_d;
        ny_q          <= ny_d;
      end else begin
        req_q         <= 1'b0;
        line_start_q  <= 1'b0;
        frame_start_q <= 1'b0;
      end
    end
  end

`ifdef VTG_TEST_PATTERN_EN
  // Bar index = x*8/H_ACTIVE as a threshold compare chain (no divider).
  function automatic logic [2:0] bar_index(input logic [11:0] xp);
    logic [2:0] idx;
    idx = '0;
    for (int k = 1; k < 8; k++) begin
      if ({xp, 3'b000} >= 15'(k * H_ACTIVE)) idx = 3'(k);
    end
    return idx;
  endfunction
`endif

  // Decode the issued position; blank while nothing is issued.
  always_comb begin
    pix_d = vtg_idle(SYNC_POL);
    if (valid_q) begin
      pix_d.de    = req_q;
      pix_d.hsync = ((x_q >= H_SYNC_BEG) && (x_q < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
      pix_d.vsync = ((y_q >= V_SYNC_BEG) && (y_q < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
`ifdef VTG_TEST_PATTERN_EN
      pix_d.rgb   = bar_colour(bar_index(x_q));
`endif
    end
  end

  vtg_delay_line #(
    .PIX_LAT  (PIX_LAT),
    .SYNC_POL (SYNC_POL)
  ) u_delay (
    .clk_pix (clk_pix),
    .srst_n  (srst_n),
    .d_i     (pix_d),
    .q_o     (pix_dly)
  );

  assign x           = x_q;
  assign y           = y_q;
  assign req         = req_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign hsync       = pix_dly.hsync;
  assign vsync       = pix_dly.vsync;
  assign de          = pix_dly.de;
`ifdef VTG_TEST_PATTERN_EN
  assign rgb         = pix_dly.de ? pix_dly.rgb : 24'h000000;
`endif

endmodule
